// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one request at a time through IDLE/EXEC/WRITE/RESP,
// with lane selection, sign/zero extension and read-merge-write for sub-word stores.
module mem_stage_lsu #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_address,
    output logic              dm_wen,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merged;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
    logic                r_dm_wen;

    logic                w_req_err;
    logic                w_lat_err;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;
    logic                w_unused;

    function automatic logic f_is_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = off[0];
            2'b10:   err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] f_load_ext(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   r = rd;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] rd, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] off);
        logic [31:0] m;
        m = rd;
        if (size == 2'b00) begin
            case (off)
                2'b00:   m[7:0]   = wd[7:0];
                2'b01:   m[15:8]  = wd[7:0];
                2'b10:   m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else begin
            if (off[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
        end
        return m;
    endfunction

    assign w_req_err   = f_is_err(req_size, req_addr[1:0]);
    assign w_lat_err   = f_is_err(r_size, r_addr[1:0]);
    assign w_load_data = f_load_ext(dm_read_data, r_size, r_addr[1:0], r_unsigned);
    assign w_merged    = f_merge(dm_read_data, r_wdata, r_size, r_addr[1:0]);
    // Address bits beyond the memory window are deliberately dropped.
    assign w_unused    = ^req_addr[31:ADDR_W+2];

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;
    assign dm_address    = r_addr[ADDR_W+1:2];
    assign dm_wen        = r_dm_wen;
    assign dm_write_data = r_merged;

    // Request FSM with all outputs registered; word stores raise dm_wen on acceptance so it is high in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_merged     <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_dm_wen     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr      <= req_addr[ADDR_W+1:0];
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= EXEC;
                        if (req_we && (req_size == 2'b10) && !w_req_err) begin
                            r_dm_wen <= 1'b1;
                            r_merged <= req_wdata;
                        end else begin
                            r_dm_wen <= 1'b0;
                        end
                    end else begin
                        r_dm_wen    <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    r_dm_wen <= 1'b0;
                    if (w_lat_err) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (!r_we) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_size == 2'b10) begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_merged <= w_merged;
                        r_dm_wen <= 1'b1;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    r_dm_wen     <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_dm_wen <= 1'b0;
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_dm_wen     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width of the downstream data memory (2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address; bits above ADDR_W+1 are ignored.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  response consumed when resp_valid and resp_ready are both high at a rising edge.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned or illegal-size request.
REQ-015 SHALL have port dm_address  output  ADDR_W  word address to data memory, equal to latched addr[ADDR_W+1:2].
REQ-016 SHALL have port dm_wen  output  1  data memory write enable.
REQ-017 SHALL have port dm_write_data  output  32  data memory write word.
REQ-018 SHALL have port dm_read_data  input  32  data memory combinational read of dm_address.

Function
REQ-019 SHALL implement the FSM states IDLE, EXEC, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL, on acceptance in IDLE, latch we, size, unsigned, addr and wdata, and go to EXEC.
REQ-021 SHALL treat as an error: size 11; half with addr[0]=1; word with addr[1:0]!=00.
REQ-022 SHALL, in EXEC on error: set resp_err=1 and resp_rdata=0, keep dm_wen low, go to RESP.
REQ-023 SHALL, in EXEC on a load: select the byte/half lane of dm_read_data, extend it per unsigned, register it into resp_rdata, go to RESP.
REQ-024 SHALL use little-endian byte lanes: addr[1:0]=n selects bits [8n+7:8n]; a half at addr[1]=h selects bits [16h+15:16h].
REQ-025 SHALL, in EXEC on a word store: assert dm_wen=1 with dm_write_data=wdata, go to RESP.
REQ-026 SHALL, in EXEC on a byte/half store: register a merged word (dm_read_data with the addressed lane replaced by the wdata low bits), keep dm_wen=0, go to WRITE.
REQ-027 SHALL, in WRITE: assert dm_wen=1 with dm_write_data=merged word, go to RESP.
REQ-028 SHALL hold dm_wen=0 in every state and case not named in REQ-025/REQ-027; dm_wen SHALL never be high for more than one cycle per request.
REQ-029 SHALL, in RESP: drive resp_valid=1 and hold resp_rdata/resp_err stable until resp_ready; on handshake return to IDLE.
REQ-030 SHALL give load, word-store and error requests 2 cycles from acceptance edge to resp_valid, and byte/half stores 3 cycles.
REQ-031 SHALL keep dm_address stable from EXEC through RESP; in IDLE it holds the last latched value.
REQ-032 SHALL ignore req_* inputs in all states other than IDLE.

Reset
REQ-033 SHALL, on rst high, immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_wen=0 and clear the latched request and merged registers to 0.
REQ-034 SHALL, on reset asserted mid-request (EXEC/WRITE), abort with no memory write and no response.

Verification
REQ-035 SHALL be verified for: memory word 0x11223344 at word 4, LB at byte addr 0x13 signed -> resp_rdata 0x00000011; LH at 0x10 signed with word 0x8000FFFF -> 0xFFFFFFFF; LHU -> 0x0000FFFF; response 2 cycles after acceptance.
REQ-036 SHALL be verified for: word 0xAABBCCDD, SB 0x55 to byte addr 0x11 -> single dm_wen pulse in WRITE with 0xAABB55DD; resp_valid 3 cycles after acceptance.
REQ-037 SHALL be verified for: SW 0xDEADBEEF to 0x08 -> dm_wen in EXEC, dm_address 2; LW 0x08 then returns 0xDEADBEEF.
REQ-038 SHALL be verified for: LW at 0x02, SH at 0x03 and size 11 -> resp_err=1, resp_rdata=0, no dm_wen.
REQ-039 SHALL be verified for: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; a new req_valid is not accepted until after the handshake.
REQ-040 SHALL be verified for: rst pulsed during WRITE of an SB -> memory word unchanged, resp_valid=0, req_ready=1.
